// File: rtl/hysteresis_saturating_counter.sv
// Saturating up/down counter with hysteresis. Crossing the midpoint skips
// COERCIVITY extra states, so a reversal needs more steps to cross back.
module hysteresis_saturating_counter #(
  parameter int RANGE       = 4,
  parameter int RESET_VALUE = 0,
  parameter int COERCIVITY  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     decrement,
  input  logic                     increment,
  output logic [$clog2(RANGE)-1:0] count
);

  localparam int WIDTH = $clog2(RANGE);

  localparam logic [WIDTH-1:0] COUNT_MIN = '0;
  localparam logic [WIDTH-1:0] COUNT_MAX = WIDTH'(RANGE - 1);
  localparam logic [WIDTH-1:0] HALF_LOW  = WIDTH'(RANGE / 2 - 1);
  localparam logic [WIDTH-1:0] HALF_HIGH = WIDTH'(RANGE / 2);
  localparam logic [WIDTH-1:0] JUMP_LOW  = WIDTH'(RANGE / 2 - 1 - COERCIVITY);
  localparam logic [WIDTH-1:0] JUMP_HIGH = WIDTH'(RANGE / 2 + COERCIVITY);
  localparam logic [WIDTH-1:0] RESET_CNT = WIDTH'(RESET_VALUE);

  if (RANGE < 2 || (RANGE % 2) != 0) begin : g_bad_range
    $error("RANGE must be even and at least 2");
  end
  if (COERCIVITY < 0 || COERCIVITY > RANGE / 2 - 1) begin : g_bad_coercivity
    $error("COERCIVITY must lie in 0..RANGE/2-1");
  end
  if (RESET_VALUE < 0 || RESET_VALUE > RANGE - 1) begin : g_bad_reset_value
    $error("RESET_VALUE must lie in 0..RANGE-1");
  end

  logic [WIDTH-1:0] count_next;

  // Simultaneous or absent requests hold; a lone request steps or jumps.
  always_comb begin
    count_next = count;
    if (increment && !decrement) begin
      if (count == HALF_LOW) begin
        count_next = JUMP_HIGH;
      end else if (count != COUNT_MAX) begin
        count_next = count + 1'b1;
      end
    end else if (decrement && !increment) begin
      if (count == HALF_HIGH) begin
        count_next = JUMP_LOW;
      end else if (count != COUNT_MIN) begin
        count_next = count - 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= RESET_CNT;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_hysteresis_saturating_counter.sv
// Self-checking bench for hysteresis_saturating_counter (RANGE=4, COERCIVITY=1,
// RESET_VALUE=0) with directed scenarios and a randomized model comparison.
module tb_hysteresis_saturating_counter;

  localparam int RANGE       = 4;
  localparam int RESET_VALUE = 0;
  localparam int COERCIVITY  = 1;
  localparam int W           = $clog2(RANGE);

  logic         clock;
  logic         reset;
  logic         decrement;
  logic         increment;
  logic [W-1:0] count;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];

  hysteresis_saturating_counter #(
    .RANGE      (RANGE),
    .RESET_VALUE(RESET_VALUE),
    .COERCIVITY (COERCIVITY)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .decrement(decrement),
    .increment(increment),
    .count    (count)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model written from the counting rules in plain integers.
  function automatic int model_step(int c, bit inc, bit dec);
    int half_low;
    int half_high;
    half_low  = RANGE / 2 - 1;
    half_high = RANGE / 2;
    if (inc == dec) return c;
    if (inc) begin
      if (c == RANGE - 1) return c;
      if (c == half_low)  return half_high + COERCIVITY;
      return c + 1;
    end
    if (c == 0)         return c;
    if (c == half_high) return half_low - COERCIVITY;
    return c - 1;
  endfunction

  // Driver: apply inputs, take one edge, sample 1 time unit later.
  task automatic drive_cycle(input bit rst, input bit inc, input bit dec);
    reset     = rst;
    increment = inc;
    decrement = dec;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== W'(RESET_VALUE)) begin
      n_fail++;
      $display("FAIL reset_idle: count=%0d expected=%0d", count, RESET_VALUE);
    end
  endtask

  task automatic test_increment_ramp();
    logic [W-1:0] seq[4];
    seq = '{W'(1), W'(3), W'(3), W'(3)};
    drive_cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0);
      n_checks++;
      if (count !== seq[i]) begin
        n_fail++;
        $display("FAIL inc_ramp[%0d]: count=%0d expected=%0d", i, count, seq[i]);
      end
    end
  endtask

  task automatic test_decrement_ramp();
    logic [W-1:0] seq[4];
    seq = '{W'(2), W'(0), W'(0), W'(0)};
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1);
      n_checks++;
      if (count !== seq[i]) begin
        n_fail++;
        $display("FAIL dec_ramp[%0d]: count=%0d expected=%0d", i, count, seq[i]);
      end
    end
  endtask

  task automatic test_both_hold();
    drive_cycle(1'b1, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1);
      n_checks++;
      if (count !== W'(1)) begin
        n_fail++;
        $display("FAIL both_hold[%0d]: count=%0d expected=1", i, count);
      end
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0);
      n_checks++;
      if (count !== W'(1)) begin
        n_fail++;
        $display("FAIL idle_hold[%0d]: count=%0d expected=1", i, count);
      end
    end
  endtask

  task automatic test_reset_override();
    drive_cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (count !== W'(3)) begin
      n_fail++;
      $display("FAIL override_setup: count=%0d expected=3", count);
    end
    drive_cycle(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (count !== W'(0)) begin
      n_fail++;
      $display("FAIL override_reset: count=%0d expected=0", count);
    end
    drive_cycle(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (count !== W'(1)) begin
      n_fail++;
      $display("FAIL override_resume: count=%0d expected=1", count);
    end
  endtask

  task automatic test_random();
    int model;
    bit inc;
    bit dec;
    logic [W-1:0] exp;
    drive_cycle(1'b1, 1'b0, 1'b0);
    model = RESET_VALUE;
    for (int i = 0; i < 100; i++) begin
      inc   = 1'($urandom_range(0, 1));
      dec   = 1'($urandom_range(0, 1));
      model = model_step(model, inc, dec);
      exp_q.push_back(W'(model));
      drive_cycle(1'b0, inc, dec);
      exp = exp_q.pop_front();
      n_checks++;
      if (count !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] inc=%0b dec=%0b: count=%0d expected=%0d",
                 i, inc, dec, count, exp);
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    increment = 1'b0;
    decrement = 1'b0;
    test_reset();
    test_increment_ramp();
    test_decrement_ramp();
    test_both_hold();
    test_reset_override();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
